vend_ctrl: RTL and testbench
============================

# vend_ctrl

Parametrised vending controller, successor to the fixed two-product `vending_machine`. Accepts coins one at a time through a valid strobe, keeps per-product stock counters and a running sales total, and vends any of `NUM_PRODUCTS` products. Returns change as a sequence of discrete coin pulses, largest denomination first. Sits between the coin-acceptor/keypad front end and the dispenser/coin-hopper drivers.

## Interface
- `NUM_PRODUCTS`, 4: number of products (≥2); `SEL_W = $clog2(NUM_PRODUCTS)` is a localparam.
- `AMT_W`, 8: credit register width.
- `TOTAL_W`, 16: sales-total width.
- `STOCK_W`, 4: per-product stock counter width.
- `INIT_STOCK`, 5: stock loaded into every product at reset.
- `BASE_PRICE`, 3: price of product 0.
- `PRICE_STEP`, 2: price increment per product index; price(i) = BASE_PRICE + i*PRICE_STEP.
- `clk  in  1` — clock. Single clock domain; all state is updated on the rising edge.
- `rst  in  1` — reset. Synchronous, active-high.
- `enable  in  1`: low freezes all state; the inputs are ignored and no pulses are issued.
- `coin_valid  in  1`: coin-insert strobe.
- `coin_type  in  2`: 00=1, 01=2, 10=5, 11=10.
- `sel_valid  in  1`: product-select strobe.
- `sel  in  SEL_W`: selected product index.
- `cancel  in  1`: refund request.
- `amount  out  AMT_W`: current credit.
- `total  out  TOTAL_W`: cumulative sales, wraps modulo 2^TOTAL_W.
- `vend_valid  out  1`: one-cycle vend pulse.
- `product  out  SEL_W`: index of the vended product; valid while `vend_valid` is high.
- `change_valid  out  1`: one-cycle pulse per change coin.
- `change_coin  out  2`: change coin denomination; same encoding as `coin_type`.
- `reject  out  1`: one-cycle pulse when a coin or selection is refused.
- `busy  out  1`: high when the state is not IDLE.
- `sold_out  out  NUM_PRODUCTS`: bit i is set when stock[i] == 0.

## Operation
- States: IDLE, CHANGE.
- All outputs are registered.
- Reset values: `amount`=0, `total`=0, `vend_valid`, `change_valid`, `reject` = 0, `product`=0, `change_coin`=0, `busy`=0, all stocks = INIT_STOCK, `sold_out`=0, state = IDLE.
- Priority in IDLE (enable=1): `cancel` > `sel_valid` > `coin_valid`.
  - `cancel`: state → CHANGE. If `coin_valid` is also high, the coin is rejected.
  - `sel_valid` with stock[sel] ≠ 0, `amount` ≥ price(sel) and sel < NUM_PRODUCTS: the selection is accepted.
    - `amount` -= price; `total` += price; stock[sel] -= 1.
    - `vend_valid`=1, `product`=sel; state → CHANGE.
    - A simultaneous coin is rejected.
  - `sel_valid` otherwise: `reject`=1. A simultaneous coin is still processed normally.
  - `coin_valid`: the coin is added if `amount` + value ≤ 2^AMT_W−1; otherwise `reject`=1 and `amount` is unchanged.
- Credit persists in IDLE across cycles until a vend or a cancel.
- CHANGE, per cycle:
  - `amount`==0: state → IDLE, no pulse.
  - Otherwise: `change_valid`=1, `change_coin` = largest denomination ≤ `amount`, and `amount` is decremented by that value.
- `coin_valid` or `sel_valid` while in CHANGE: `reject`=1 and no state change.
- `cancel` in CHANGE: ignored.

## Timing
- Coin accepted at edge N: `amount` is updated and visible from N+1.
- Selection accepted at edge N:
  - `vend_valid` is high for cycle N+1.
  - The new `amount`, `total` and `sold_out` are visible from N+1.
  - The first change pulse can appear at N+2.
- Refund of value V takes k+1 cycles in CHANGE (k = greedy coin count); `busy` falls one cycle after the last pulse.
- `reject` is asserted the cycle after the offending strobe, for exactly one cycle.
- `rst` mid-CHANGE: the remaining change is discarded, all state returns to reset values on the next edge, and the pulses stop immediately.
- `enable` low mid-CHANGE: the sequence pauses and resumes when `enable` returns high. Pulse outputs are forced to 0 while `enable` is low.

## Configuration
- `VEND_REFILL_EN`
  - Defined: adds input port `refill` (1 bit). `refill`=1 in IDLE with enable=1 reloads every stock to INIT_STOCK on the next edge and clears `sold_out`. `refill` has higher priority than `cancel`, and any strobe in the same cycle is rejected. `refill` is ignored in CHANGE.
  - Undefined: the port is absent and stock is restored only by `rst`.

## Test plan
- Defaults; insert coins 10 and 2, select product 2 (price 7) → `vend_valid`, `product`=2, `amount`=5, `total`=7; next cycle `change_coin`=10b (5); `amount`=0; `busy` falls.
- Credit 8, `cancel` → change pulses 5, 2, 1 on consecutive cycles; `amount`=0, `total` unchanged.
- Vend product 0 five times (credit 3 each) → `sold_out[0]`=1; sixth select → `reject`, `amount` stays 3.
- Credit 4, select product 1 (price 5) → `reject`; `amount`=4; no `vend_valid`.
- Credit 250, coin 10 → `reject`, `amount`=250; coin 5 → `amount`=255.
- `rst` during a three-coin refund → no further `change_valid`; all outputs at reset values; stocks back to 5.

Source files
------------

// File: rtl/vend_ctrl.sv
// Parametrised vending controller: coin credit, per-product stock, sales total, greedy change.
// Optional macro VEND_REFILL_EN adds a `refill` input that reloads every stock counter.
module vend_ctrl #(
    parameter int NUM_PRODUCTS = 4,
    parameter int AMT_W        = 8,
    parameter int TOTAL_W      = 16,
    parameter int STOCK_W      = 4,
    parameter int INIT_STOCK   = 5,
    parameter int BASE_PRICE   = 3,
    parameter int PRICE_STEP   = 2,
    localparam int SEL_W       = $clog2(NUM_PRODUCTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    coin_valid,
    input  logic [1:0]              coin_type,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    cancel,
`ifdef VEND_REFILL_EN
    input  logic                    refill,
`endif
    output logic [AMT_W-1:0]        amount,
    output logic [TOTAL_W-1:0]      total,
    output logic                    vend_valid,
    output logic [SEL_W-1:0]        product,
    output logic                    change_valid,
    output logic [1:0]              change_coin,
    output logic                    reject,
    output logic                    busy,
    output logic [NUM_PRODUCTS-1:0] sold_out
);

    typedef enum logic {IDLE, CHANGE} state_t;

    state_t                    state_q, state_d;
    logic [STOCK_W-1:0]        stock_q [NUM_PRODUCTS];
    logic [STOCK_W-1:0]        stock_d [NUM_PRODUCTS];
    logic [AMT_W-1:0]          amount_d;
    logic [TOTAL_W-1:0]        total_d;
    logic                      vend_d, change_d, reject_d;
    logic [SEL_W-1:0]          product_d;
    logic [1:0]                coin_d;
    logic [NUM_PRODUCTS-1:0]   sold_d;
    logic [AMT_W-1:0]          price;
    logic [AMT_W:0]            coin_sum;
    logic                      sel_ok, coin_ok, refill_req;

    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] t);
        case (t)
            2'b00:   return AMT_W'(1);
            2'b01:   return AMT_W'(2);
            2'b10:   return AMT_W'(5);
            default: return AMT_W'(10);
        endcase
    endfunction

`ifdef VEND_REFILL_EN
    assign refill_req = refill;
`else
    assign refill_req = 1'b0;
`endif

    assign price    = AMT_W'(BASE_PRICE) + AMT_W'(PRICE_STEP) * AMT_W'(sel);
    assign coin_sum = {1'b0, amount} + {1'b0, coin_value(coin_type)};
    // Range check first so an out-of-range sel never gates on a bogus stock entry.
    assign sel_ok   = (32'(sel) < NUM_PRODUCTS) && (stock_q[sel] != '0) && (amount >= price);

    always_comb begin
        state_d   = state_q;
        amount_d  = amount;
        total_d   = total;
        stock_d   = stock_q;
        vend_d    = 1'b0;
        change_d  = 1'b0;
        reject_d  = 1'b0;
        product_d = product;
        coin_d    = change_coin;
        coin_ok   = 1'b1;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (refill_req) begin
                        for (int unsigned i = 0; i < NUM_PRODUCTS; i++)
                            stock_d[i] = STOCK_W'(INIT_STOCK);
                        reject_d = coin_valid | sel_valid;
                    end else if (cancel) begin
                        state_d  = CHANGE;
                        reject_d = coin_valid;
                    end else begin
                        if (sel_valid) begin
                            if (sel_ok) begin
                                amount_d     = amount - price;
                                total_d      = total + TOTAL_W'(price);
                                stock_d[sel] = stock_q[sel] - STOCK_W'(1);
                                vend_d       = 1'b1;
                                product_d    = sel;
                                state_d      = CHANGE;
                                coin_ok      = 1'b0;
                                reject_d     = coin_valid;
                            end else begin
                                reject_d = 1'b1;
                            end
                        end
                        if (coin_valid && coin_ok) begin
                            if (coin_sum[AMT_W] == 1'b0)
                                amount_d = coin_sum[AMT_W-1:0];
                            else
                                reject_d = 1'b1;
                        end
                    end
                end
                CHANGE: begin
                    reject_d = coin_valid | sel_valid;
                    if (amount == '0) begin
                        state_d = IDLE;
                    end else begin
                        change_d = 1'b1;
                        if (amount >= AMT_W'(10))     coin_d = 2'b11;
                        else if (amount >= AMT_W'(5)) coin_d = 2'b10;
                        else if (amount >= AMT_W'(2)) coin_d = 2'b01;
                        else                          coin_d = 2'b00;
                        amount_d = amount - coin_value(coin_d);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        for (int unsigned i = 0; i < NUM_PRODUCTS; i++)
            sold_d[i] = (stock_d[i] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            amount       <= '0;
            total        <= '0;
            vend_valid   <= 1'b0;
            product      <= '0;
            change_valid <= 1'b0;
            change_coin  <= '0;
            reject       <= 1'b0;
            busy         <= 1'b0;
            sold_out     <= '0;
            for (int unsigned i = 0; i < NUM_PRODUCTS; i++)
                stock_q[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            state_q      <= state_d;
            amount       <= amount_d;
            total        <= total_d;
            vend_valid   <= vend_d;
            product      <= product_d;
            change_valid <= change_d;
            change_coin  <= coin_d;
            reject       <= reject_d;
            busy         <= (state_d != IDLE);
            sold_out     <= sold_d;
            stock_q      <= stock_d;
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: vector table for single-cycle behaviour, hand sequences for
// sell-out, credit overflow, long refunds, enable pause and reset mid-refund.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic       coin_valid, sel_valid, cancel;
    logic [1:0] coin_type, sel;
`ifdef VEND_REFILL_EN
    logic       refill = 1'b0;
`endif
    logic [7:0]  amount;
    logic [15:0] total;
    logic        vend_valid, change_valid, reject, busy;
    logic [1:0]  product, change_coin;
    logic [3:0]  sold_out;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int exp_total = 0;

    vend_ctrl #(.NUM_PRODUCTS(4), .AMT_W(8), .TOTAL_W(16), .STOCK_W(4),
                .INIT_STOCK(5), .BASE_PRICE(3), .PRICE_STEP(2)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
`ifdef VEND_REFILL_EN
        .refill(refill),
`endif
        .amount(amount), .total(total), .vend_valid(vend_valid), .product(product),
        .change_valid(change_valid), .change_coin(change_coin), .reject(reject),
        .busy(busy), .sold_out(sold_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [1:0] ct;
        logic       sv;
        logic [1:0] s;
        logic       c;
        int         amt;
        int         tot;
        int         vend;
        int         prod;
        int         chg;
        int         coin;
        int         rej;
        int         bsy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic cv, logic [1:0] ct, logic sv, logic [1:0] s, logic c,
                                int amt, int tot, int vend, int prod, int chg, int coin,
                                int rej, int bsy);
        vec_t v;
        v.cv = cv; v.ct = ct; v.sv = sv; v.s = s; v.c = c;
        v.amt = amt; v.tot = tot; v.vend = vend; v.prod = prod;
        v.chg = chg; v.coin = coin; v.rej = rej; v.bsy = bsy;
        return v;
    endfunction

    function automatic void chk(string name, int act, int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic cv, input logic [1:0] ct, input logic sv,
                        input logic [1:0] s, input logic c);
        coin_valid = cv; coin_type = ct; sel_valid = sv; sel = s; cancel = c;
        @(posedge clk);
        #1;
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic coin(input logic [1:0] t);
        step(1'b1, t, 1'b0, 2'b00, 1'b0);
    endtask

    // Run idle cycles until busy drops, totalling the change coins paid out.
    task automatic drain(input string name, input int exp_sum, input int exp_n);
        int sum = 0;
        int n   = 0;
        int val;
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            idle();
            if (change_valid) begin
                case (change_coin)
                    2'b00: val = 1;
                    2'b01: val = 2;
                    2'b10: val = 5;
                    default: val = 10;
                endcase
                sum += val;
                n++;
            end
            if (!busy) done = 1;
        end
        chk({name, "_done"}, int'(done), 1);
        chk({name, "_sum"}, sum, exp_sum);
        chk({name, "_count"}, n, exp_n);
        chk({name, "_amount"}, int'(amount), 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1;
        coin_valid = 1'b0; coin_type = 2'b00; sel_valid = 1'b0; sel = 2'b00; cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_amount", int'(amount), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sold_out", int'(sold_out), 0);
        chk("rst_pulses", int'({vend_valid, change_valid, reject}), 0);
        rst = 1'b0;

        //          cv ct    sv s     c  amt tot vend prod chg coin rej busy
        vt.push_back(mk(1, 2'd3, 0, 2'd0, 0, 10,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'd1, 0, 2'd0, 0, 12,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 2'd0, 1, 2'd2, 0,  5,  7, 1, 2, 0, 0, 0, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  0,  7, 0, 0, 1, 2, 0, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  0,  7, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'd2, 0, 2'd0, 0,  5,  7, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'd1, 0, 2'd0, 0,  7,  7, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'd0, 0, 2'd0, 0,  8,  7, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 1,  8,  7, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  3,  7, 0, 0, 1, 2, 0, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  1,  7, 0, 0, 1, 1, 0, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  0,  7, 0, 0, 1, 0, 0, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  0,  7, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'd1, 0, 2'd0, 0,  2,  7, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'd1, 0, 2'd0, 0,  4,  7, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 2'd0, 1, 2'd1, 0,  4,  7, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  4,  7, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'd3, 0, 2'd0, 1,  4,  7, 0, 0, 0, 0, 1, 1));
        vt.push_back(mk(1, 2'd0, 0, 2'd0, 0,  2,  7, 0, 0, 1, 1, 1, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  0,  7, 0, 0, 1, 1, 0, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  0,  7, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'd2, 0, 2'd0, 0,  5,  7, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'd3, 1, 2'd0, 0,  2, 10, 1, 0, 0, 0, 1, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  0, 10, 0, 0, 1, 1, 0, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  0, 10, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'd0, 1, 2'd3, 0,  1, 10, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 1,  1, 10, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  0, 10, 0, 0, 1, 0, 0, 1));
        vt.push_back(mk(0, 2'd0, 0, 2'd0, 0,  0, 10, 0, 0, 0, 0, 0, 0));

        foreach (vt[i]) begin
            step(vt[i].cv, vt[i].ct, vt[i].sv, vt[i].s, vt[i].c);
            chk($sformatf("v%0d_amount", i), int'(amount), vt[i].amt);
            chk($sformatf("v%0d_total", i), int'(total), vt[i].tot);
            chk($sformatf("v%0d_vend", i), int'(vend_valid), vt[i].vend);
            if (vt[i].vend != 0) chk($sformatf("v%0d_product", i), int'(product), vt[i].prod);
            chk($sformatf("v%0d_change_valid", i), int'(change_valid), vt[i].chg);
            if (vt[i].chg != 0) chk($sformatf("v%0d_change_coin", i), int'(change_coin), vt[i].coin);
            chk($sformatf("v%0d_reject", i), int'(reject), vt[i].rej);
            chk($sformatf("v%0d_busy", i), int'(busy), vt[i].bsy);
            chk($sformatf("v%0d_sold_out", i), int'(sold_out), 0);
        end
        exp_total = 10;

        // Product 0 has 4 left: sell them all.
        for (int k = 0; k < 4; k++) begin
            coin(2'b01);
            coin(2'b00);
            step(1'b0, 2'b00, 1'b1, 2'd0, 1'b0);
            exp_total += 3;
            chk("sell_vend", int'(vend_valid), 1);
            chk("sell_amount", int'(amount), 0);
            chk("sell_total", int'(total), exp_total);
            chk("sell_sold_out", int'(sold_out), (k == 3) ? 1 : 0);
            idle();
            chk("sell_busy_low", int'(busy), 0);
        end
        coin(2'b01);
        coin(2'b00);
        step(1'b0, 2'b00, 1'b1, 2'd0, 1'b0);
        chk("soldout_reject", int'(reject), 1);
        chk("soldout_vend", int'(vend_valid), 0);
        chk("soldout_amount", int'(amount), 3);
        chk("soldout_total", int'(total), exp_total);
        step(1'b0, 2'b00, 1'b0, 2'd0, 1'b1);
        drain("soldout_refund", 3, 2);

        // Credit ceiling.
        for (int k = 0; k < 25; k++) coin(2'b11);
        chk("ovf_amount250", int'(amount), 250);
        coin(2'b11);
        chk("ovf_reject", int'(reject), 1);
        chk("ovf_amount_hold", int'(amount), 250);
        coin(2'b10);
        chk("ovf_reject_clear", int'(reject), 0);
        chk("ovf_amount255", int'(amount), 255);
        step(1'b0, 2'b00, 1'b0, 2'd0, 1'b1);
        chk("ovf_busy", int'(busy), 1);
        drain("ovf_refund", 255, 26);
        chk("ovf_total", int'(total), exp_total);

        // Enable low pauses the refund.
        coin(2'b10); coin(2'b01); coin(2'b00);
        step(1'b0, 2'b00, 1'b0, 2'd0, 1'b1);
        idle();
        chk("en_first_coin", int'(change_coin), 2);
        chk("en_first_amount", int'(amount), 3);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b11, 1'b0, 2'd0, 1'b0);
            chk("en_paused_pulse", int'(change_valid), 0);
            chk("en_paused_reject", int'(reject), 0);
            chk("en_paused_amount", int'(amount), 3);
            chk("en_paused_busy", int'(busy), 1);
        end
        enable = 1'b1;
        idle();
        chk("en_resume_valid", int'(change_valid), 1);
        chk("en_resume_coin", int'(change_coin), 1);
        chk("en_resume_amount", int'(amount), 1);
        drain("en_rest", 1, 1);

        // Reset in the middle of a three-coin refund.
        coin(2'b10); coin(2'b01); coin(2'b00);
        step(1'b0, 2'b00, 1'b0, 2'd0, 1'b1);
        idle();
        chk("rr_first_pulse", int'(change_valid), 1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("rr_change_valid", int'(change_valid), 0);
        chk("rr_amount", int'(amount), 0);
        chk("rr_total", int'(total), 0);
        chk("rr_busy", int'(busy), 0);
        chk("rr_sold_out", int'(sold_out), 0);
        chk("rr_vend_reject", int'({vend_valid, reject}), 0);
        chk("rr_product_coin", int'({product, change_coin}), 0);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("rr_no_pulse", int'(change_valid), 0);
        end
        // Product 0 was sold out before the reset; stock must be back.
        coin(2'b01); coin(2'b00);
        step(1'b0, 2'b00, 1'b1, 2'd0, 1'b0);
        chk("rr_restock_vend", int'(vend_valid), 1);
        chk("rr_restock_total", int'(total), 3);
        chk("rr_restock_sold_out", int'(sold_out), 0);
        idle();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
